sm_bcd_display: RTL



---
 rtl/sm_bcd_display.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sm_bcd_display.sv
// sm_bcd_display: sign-magnitude to 3-digit BCD converter with active-low 7-segment drive.
// Ports: clk/rst_n clock and async active-low reset; start/mag/sign conversion request
// and operand; busy/done status; neg/bcd_h/bcd_t/bcd_o registered result;
// seg_s/seg_h/seg_t/seg_o active-low {g,f,e,d,c,b,a} patterns with leading-zero blanking.
module sm_bcd_display #(
   parameter int ITER = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] mag,
   input  logic       sign,
   output logic       busy,
   output logic       done,
   output logic       neg,
   output logic [3:0] bcd_h,
   output logic [3:0] bcd_t,
   output logic [3:0] bcd_o,
   output logic [6:0] seg_s,
   output logic [6:0] seg_h,
   output logic [6:0] seg_t,
   output logic [6:0] seg_o
);
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [2:0] LAST  = 3'(ITER - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t      state_q, state_d;
   logic [19:0] work_q, work_d, adj;
   logic [2:0]  cnt_q, cnt_d;
   logic        sign_q, sign_d, nz_q, nz_d, neg_q, neg_d;
   logic [3:0]  bh_q, bh_d, bt_q, bt_d, bo_q, bo_d;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = BLANK;
      endcase
   endfunction

   // BCD nibbles sit above the binary byte; correct them before each shift
   assign adj = {add3(work_q[19:16]), add3(work_q[15:12]), add3(work_q[11:8]), work_q[7:0]};

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      nz_d    = nz_q;
      neg_d   = neg_q;
      bh_d    = bh_q;
      bt_d    = bt_q;
      bo_d    = bo_q;
      if (state_q == IDLE && start) begin
         work_d  = {12'b0, mag};
         sign_d  = sign;
         nz_d    = |mag;
         cnt_d   = 3'd0;
         state_d = SHIFT;
      end else if (state_q == SHIFT) begin
         work_d = {adj[18:0], 1'b0};
         cnt_d  = cnt_q + 3'd1;
         if (cnt_q == LAST) begin
            bh_d    = work_d[19:16];
            bt_d    = work_d[15:12];
            bo_d    = work_d[11:8];
            neg_d   = sign_q & nz_q;
            state_d = DONE;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         nz_q    <= 1'b0;
         neg_q   <= 1'b0;
         bh_q    <= '0;
         bt_q    <= '0;
         bo_q    <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         nz_q    <= nz_d;
         neg_q   <= neg_d;
         bh_q    <= bh_d;
         bt_q    <= bt_d;
         bo_q    <= bo_d;
      end
   end

   assign busy  = state_q != IDLE;
   assign done  = state_q == DONE;
   assign neg   = neg_q;
   assign bcd_h = bh_q;
   assign bcd_t = bt_q;
   assign bcd_o = bo_q;
   assign seg_s = neg_q ? 7'b0111111 : BLANK;
   assign seg_h = (bh_q == 4'd0) ? BLANK : seg7(bh_q);
   assign seg_t = (bh_q == 4'd0 && bt_q == 4'd0) ? BLANK : seg7(bt_q);
   assign seg_o = seg7(bo_q);
endmodule
